// File: rtl/retirement_packer_if.sv
// Record-in / bundle-out bus of the retirement packer.
// Signal suffixes are taken from the packer's point of view.
interface retirement_packer_if #(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ILASTSIZE_LEN  = 1,
    parameter int unsigned ITYPE_LEN      = 3,
    parameter int unsigned CAUSE_LEN      = 5,
    parameter int unsigned PRIV_LEN       = 2
);
    logic                                         iretire_i;
    logic [ILASTSIZE_LEN-1:0]                     ilastsize_i;
    logic [ITYPE_LEN-1:0]                         itype_i;
    logic [CAUSE_LEN-1:0]                         cause_i;
    logic [XLEN-1:0]                              tval_i;
    logic [PRIV_LEN-1:0]                          priv_i;
    logic [XLEN-1:0]                              iaddr_i;
    logic                                         ready_o;

    logic [NrRetiredInstr-1:0]                    iretire_o;
    logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0] ilastsize_o;
    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]     itype_o;
    logic [CAUSE_LEN-1:0]                         cause_o;
    logic [XLEN-1:0]                              tval_o;
    logic [PRIV_LEN-1:0]                          priv_o;
    logic [NrRetiredInstr-1:0][XLEN-1:0]          iaddr_o;
    logic                                         valid_o;
    logic                                         ready_i;

    modport slave (
        input  iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        output ready_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               valid_o
    );

    modport master (
        output iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        input  ready_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               valid_o
    );
endinterface

// File: rtl/retirement_packer.sv
// Packs a one-record-per-cycle retirement stream into NrRetiredInstr-wide bundles,
// with one closed group of buffering behind a valid/ready output register.
module retirement_packer #(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned TimeoutCycles  = 16,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ILASTSIZE_LEN  = 1,
    parameter int unsigned ITYPE_LEN      = 3,
    parameter int unsigned CAUSE_LEN      = 5,
    parameter int unsigned PRIV_LEN       = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    retirement_packer_if.slave  bus
);
    localparam int unsigned CW = $clog2(NrRetiredInstr + 1);
    localparam int unsigned IW = $clog2(TimeoutCycles);
    localparam logic [CW-1:0] FULL     = CW'(NrRetiredInstr);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TimeoutCycles - 1);

    logic [NrRetiredInstr-1:0][XLEN-1:0]          addr_q, addr_d, cl_addr;
    logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0] size_q, size_d, cl_size;
    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]     type_q, type_d, cl_type;
    logic [CW-1:0]        count_q, count_d, cl_count;
    logic [PRIV_LEN-1:0]  priv_q, priv_d, cl_priv;
    logic [CAUSE_LEN-1:0] cause_q, cause_d, cl_cause;
    logic [XLEN-1:0]      tval_q, tval_d, cl_tval;
    logic                 pending_q, pending_d;
    logic [IW-1:0]        idle_q, idle_d;

    logic                                         out_valid_q, out_valid_d;
    logic [NrRetiredInstr-1:0]                    out_mask_q, out_mask_d;
    logic [NrRetiredInstr-1:0][XLEN-1:0]          out_addr_q, out_addr_d;
    logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0] out_size_q, out_size_d;
    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]     out_type_q, out_type_d;
    logic [CAUSE_LEN-1:0] out_cause_q, out_cause_d;
    logic [XLEN-1:0]      out_tval_q, out_tval_d;
    logic [PRIV_LEN-1:0]  out_priv_q, out_priv_d;

    logic out_free, mismatch, rdy, accept, rec_trap, load_out;

    assign out_free = !out_valid_q || bus.ready_i;
    assign mismatch = bus.iretire_i && !pending_q && (count_q != '0) && (bus.priv_i != priv_q);
    assign rdy      = !pending_q && !(mismatch && !out_free);
    assign accept   = bus.iretire_i && rdy;
    assign rec_trap = (bus.itype_i == ITYPE_LEN'(1)) || (bus.itype_i == ITYPE_LEN'(2));

    always_comb begin
        addr_d    = addr_q;
        size_d    = size_q;
        type_d    = type_q;
        count_d   = count_q;
        priv_d    = priv_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        pending_d = pending_q;
        idle_d    = idle_q;
        cl_addr   = addr_q;
        cl_size   = size_q;
        cl_type   = type_q;
        cl_count  = count_q;
        cl_priv   = priv_q;
        cl_cause  = cause_q;
        cl_tval   = tval_q;
        load_out  = 1'b0;

        if (pending_q) begin
            if (out_free) begin
                load_out  = 1'b1;
                pending_d = 1'b0;
                count_d   = '0;
                addr_d    = '0;
                size_d    = '0;
                type_d    = '0;
                cause_d   = '0;
                tval_d    = '0;
            end
        end else if (mismatch) begin
            // Old group leaves untouched via cl_*; the record then seeds a new group.
            idle_d = '0;
            if (out_free) begin
                load_out   = 1'b1;
                addr_d     = '0;
                size_d     = '0;
                type_d     = '0;
                addr_d[0]  = bus.iaddr_i;
                size_d[0]  = bus.ilastsize_i;
                type_d[0]  = bus.itype_i;
                count_d    = CW'(1);
                priv_d     = bus.priv_i;
                cause_d    = rec_trap ? bus.cause_i : '0;
                tval_d     = rec_trap ? bus.tval_i : '0;
                pending_d  = (bus.itype_i != '0);
            end else begin
                pending_d = 1'b1;
            end
        end else if (accept) begin
            idle_d = '0;
            for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
                if (CW'(i) == count_q) begin
                    addr_d[i] = bus.iaddr_i;
                    size_d[i] = bus.ilastsize_i;
                    type_d[i] = bus.itype_i;
                end
            end
            count_d = count_q + CW'(1);
            if (count_q == '0) priv_d = bus.priv_i;
            if (rec_trap) begin
                cause_d = bus.cause_i;
                tval_d  = bus.tval_i;
            end
            if ((count_d == FULL) || (bus.itype_i != '0)) begin
                cl_addr  = addr_d;
                cl_size  = size_d;
                cl_type  = type_d;
                cl_count = count_d;
                cl_priv  = priv_d;
                cl_cause = cause_d;
                cl_tval  = tval_d;
                if (out_free) begin
                    load_out = 1'b1;
                    count_d  = '0;
                    addr_d   = '0;
                    size_d   = '0;
                    type_d   = '0;
                    cause_d  = '0;
                    tval_d   = '0;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end else if (count_q != '0) begin
            if (idle_q == IDLE_MAX) begin
                idle_d = '0;
                if (out_free) begin
                    load_out = 1'b1;
                    count_d  = '0;
                    addr_d   = '0;
                    size_d   = '0;
                    type_d   = '0;
                    cause_d  = '0;
                    tval_d   = '0;
                end else begin
                    pending_d = 1'b1;
                end
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_addr_d  = out_addr_q;
        out_size_d  = out_size_q;
        out_type_d  = out_type_q;
        out_cause_d = out_cause_q;
        out_tval_d  = out_tval_q;
        out_priv_d  = out_priv_q;
        if (load_out) begin
            out_valid_d = 1'b1;
            for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
                out_mask_d[i] = (CW'(i) < cl_count);
            end
            out_addr_d  = cl_addr;
            out_size_d  = cl_size;
            out_type_d  = cl_type;
            out_cause_d = cl_cause;
            out_tval_d  = cl_tval;
            out_priv_d  = cl_priv;
        end else if (out_valid_q && bus.ready_i) begin
            out_valid_d = 1'b0;
            out_mask_d  = '0;
            out_addr_d  = '0;
            out_size_d  = '0;
            out_type_d  = '0;
            out_cause_d = '0;
            out_tval_d  = '0;
            out_priv_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            size_q      <= '0;
            type_q      <= '0;
            count_q     <= '0;
            priv_q      <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            pending_q   <= 1'b0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_addr_q  <= '0;
            out_size_q  <= '0;
            out_type_q  <= '0;
            out_cause_q <= '0;
            out_tval_q  <= '0;
            out_priv_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            size_q      <= size_d;
            type_q      <= type_d;
            count_q     <= count_d;
            priv_q      <= priv_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            pending_q   <= pending_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_addr_q  <= out_addr_d;
            out_size_q  <= out_size_d;
            out_type_q  <= out_type_d;
            out_cause_q <= out_cause_d;
            out_tval_q  <= out_tval_d;
            out_priv_q  <= out_priv_d;
        end
    end

    assign bus.ready_o     = rdy;
    assign bus.valid_o     = out_valid_q;
    assign bus.iretire_o   = out_mask_q;
    assign bus.iaddr_o     = out_addr_q;
    assign bus.ilastsize_o = out_size_q;
    assign bus.itype_o     = out_type_q;
    assign bus.cause_o     = out_cause_q;
    assign bus.tval_o      = out_tval_q;
    assign bus.priv_o      = out_priv_q;
endmodule

// File: tb/tb_retirement_packer.sv
// Scoreboard bench for retirement_packer: a grouping model pushes expected bundles
// as records are accepted; a negedge monitor pops and compares delivered bundles.
module tb_retirement_packer;
    localparam int unsigned NR = 2;
    localparam int unsigned TO = 16;
    localparam int unsigned XL = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    retirement_packer_if #(.NrRetiredInstr(NR), .XLEN(XL)) bus ();

    retirement_packer #(.NrRetiredInstr(NR), .TimeoutCycles(TO), .XLEN(XL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    mask;
        logic [XL-1:0] a0, a1;
        logic [2:0]    t0, t1;
        logic          s0, s1;
        logic [4:0]    cause;
        logic [XL-1:0] tval;
        logic [1:0]    priv;
    } bundle_t;

    bundle_t sb[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    int            m_cnt;
    logic [XL-1:0] m_a[2];
    logic [2:0]    m_t[2];
    logic          m_s[2];
    logic [1:0]    m_p;
    logic [4:0]    m_c;
    logic [XL-1:0] m_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_a[0] = '0; m_a[1] = '0;
        m_t[0] = '0; m_t[1] = '0;
        m_s[0] = 1'b0; m_s[1] = 1'b0;
        m_c = '0;
        m_v = '0;
    endtask

    task automatic push_group();
        bundle_t b;
        b.mask  = (m_cnt == 2) ? 2'b11 : (m_cnt == 1) ? 2'b01 : 2'b00;
        b.a0 = m_a[0]; b.a1 = m_a[1];
        b.t0 = m_t[0]; b.t1 = m_t[1];
        b.s0 = m_s[0]; b.s1 = m_s[1];
        b.cause = m_c;
        b.tval  = m_v;
        b.priv  = m_p;
        sb.push_back(b);
        model_clear();
    endtask

    task automatic model_accept(input logic [XL-1:0] a, input logic [2:0] t, input logic s,
                                input logic [1:0] p, input logic [4:0] c, input logic [XL-1:0] v);
        if (m_cnt > 0 && p != m_p) push_group();
        if (m_cnt == 0) m_p = p;
        m_a[m_cnt] = a;
        m_t[m_cnt] = t;
        m_s[m_cnt] = s;
        if (t == 3'd1 || t == 3'd2) begin
            m_c = c;
            m_v = v;
        end
        m_cnt++;
        if (m_cnt == NR || t != 3'd0) push_group();
    endtask

    task automatic model_flush();
        if (m_cnt > 0) push_group();
    endtask

    // Holds the record on the bus until it is accepted; returns the cycles spent.
    task automatic send(input logic [XL-1:0] a, input logic [2:0] t, input logic [1:0] p,
                        input logic [4:0] c, input logic [XL-1:0] v, output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        bus.iretire_i   = 1'b1;
        bus.iaddr_i     = a;
        bus.itype_i     = t;
        bus.priv_i      = p;
        bus.cause_i     = c;
        bus.tval_i      = v;
        bus.ilastsize_i = a[2];
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = bus.ready_o;
            tries++;
            @(posedge clk);
        end
        if (!acc) chk("accept_wait", 64'd0, 64'd1);
        else model_accept(a, t, a[2], p, c, v);
        #1 bus.iretire_i = 1'b0;
    endtask

    logic          prev_hold = 1'b0;
    logic [63:0]   prev_addr;
    logic [1:0]    prev_mask;
    bundle_t       e;

    always @(negedge clk) begin
        if (!rst && prev_hold) begin
            chk("hold_valid", {63'd0, bus.valid_o}, 64'd1);
            chk("hold_addr", bus.iaddr_o, prev_addr);
            chk("hold_mask", {62'd0, bus.iretire_o}, {62'd0, prev_mask});
        end
        prev_hold = bus.valid_o && !bus.ready_i && !rst;
        prev_addr = bus.iaddr_o;
        prev_mask = bus.iretire_o;
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_bundle", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("mask", {62'd0, bus.iretire_o}, {62'd0, e.mask});
                chk("addr0", {32'd0, bus.iaddr_o[0]}, {32'd0, e.a0});
                chk("addr1", {32'd0, bus.iaddr_o[1]}, {32'd0, e.a1});
                chk("itype", {58'd0, bus.itype_o}, {58'd0, e.t1, e.t0});
                chk("isize", {62'd0, bus.ilastsize_o}, {62'd0, e.s1, e.s0});
                chk("cause", {59'd0, bus.cause_o}, {59'd0, e.cause});
                chk("tval", {32'd0, bus.tval_o}, {32'd0, e.tval});
                chk("priv", {62'd0, bus.priv_o}, {62'd0, e.priv});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int tries;
    int k;

    initial begin
        model_clear();
        m_p = '0;
        bus.iretire_i = 1'b0; bus.iaddr_i = '0; bus.itype_i = '0; bus.priv_i = '0;
        bus.cause_i = '0; bus.tval_i = '0; bus.ilastsize_i = '0; bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("rst_mask", {62'd0, bus.iretire_o}, 64'd0);
        chk("rst_addr", bus.iaddr_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // two sequential records -> full bundle one cycle later
        send(32'h8000_0000, 3'd0, 2'd3, 5'd0, '0, tries);
        send(32'h8000_0004, 3'd0, 2'd3, 5'd0, '0, tries);
        @(negedge clk);
        chk("t1_latency_valid", {63'd0, bus.valid_o}, 64'd1);
        @(posedge clk); #1;

        // single exception record closes its own group
        send(32'h0000_0100, 3'd1, 2'd3, 5'd2, 32'h0000_DEAD, tries);
        @(negedge clk);
        chk("t2_latency_valid", {63'd0, bus.valid_o}, 64'd1);
        @(posedge clk); #1;

        // priv change splits the group without stalling the input
        send(32'h0000_0200, 3'd0, 2'd3, 5'd0, '0, tries);
        send(32'h0000_0204, 3'd0, 2'd0, 5'd0, '0, tries);
        chk("t3_ready_kept", tries, 64'd1);
        model_flush();
        repeat (TO + 4) @(posedge clk);
        #1;

        // exact timeout distance from the last accept
        send(32'h0000_0300, 3'd0, 2'd3, 5'd0, '0, tries);
        model_flush();
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid_o) break;
        end
        chk("t4_timeout_edges", k, 64'd16);
        repeat (3) @(posedge clk);
        #1;

        // backpressure: bundle held, next group pending, input stalled
        bus.ready_i = 1'b0;
        send(32'h0000_0400, 3'd0, 2'd1, 5'd0, '0, tries);
        send(32'h0000_0404, 3'd0, 2'd1, 5'd0, '0, tries);
        send(32'h0000_0408, 3'd0, 2'd1, 5'd0, '0, tries);
        send(32'h0000_040C, 3'd0, 2'd1, 5'd0, '0, tries);
        fork
            send(32'h0000_0410, 3'd0, 2'd1, 5'd0, '0, tries);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t5_ready_low", {63'd0, bus.ready_o}, 64'd0);
                end
                chk("t5_valid_held", {63'd0, bus.valid_o}, 64'd1);
                @(posedge clk); #1;
                bus.ready_i = 1'b1;
            end
        join
        model_flush();
        repeat (TO + 6) @(posedge clk);
        #1;

        // asynchronous reset discards output and partial group
        bus.ready_i = 1'b0;
        send(32'h0000_0500, 3'd0, 2'd3, 5'd0, '0, tries);
        send(32'h0000_0504, 3'd0, 2'd3, 5'd0, '0, tries);
        send(32'h0000_0508, 3'd0, 2'd3, 5'd0, '0, tries);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("t6_rst_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("t6_rst_mask", {62'd0, bus.iretire_o}, 64'd0);
        chk("t6_rst_addr", bus.iaddr_o, 64'd0);
        chk("t6_rst_priv", {62'd0, bus.priv_o}, 64'd0);
        sb.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        send(32'h0000_0600, 3'd0, 2'd2, 5'd0, '0, tries);
        send(32'h0000_0604, 3'd0, 2'd2, 5'd0, '0, tries);
        @(negedge clk);
        chk("t6_fresh_valid", {63'd0, bus.valid_o}, 64'd1);
        repeat (4) @(posedge clk);
        #1;

        chk("sb_empty", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/retirement_packer.md
# retirement_packer

Packs the single-retirement stream produced for the trace encoder (one retired instruction per cycle: iretire/ilastsize/itype/cause/tval/priv/iaddr) back into NrRetiredInstr-wide retirement bundles. It is the inverse of the multi-to-single retirement serializer. It sits on the receiving side of the trace path and feeds bundle-oriented consumers such as the checker and the replay model. It has a valid/ready output handshake with one bundle of internal buffering.

## Interface
- NrRetiredInstr, 2, bundle width (slots per group), ≥2
- TimeoutCycles, 16, idle cycles before a partial group is closed, ≥2
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- iretire_i  in  1  input record valid
- ilastsize_i  in  ILASTSIZE_LEN  record instruction size
- itype_i  in  ITYPE_LEN  record type (0 = sequential, 1 = exception, 2 = interrupt, other = discontinuity)
- cause_i  in  CAUSE_LEN  cause; meaningful for itype 1/2
- tval_i  in  XLEN  trap value; meaningful for itype 1/2
- priv_i  in  PRIV_LEN  privilege level of the record
- iaddr_i  in  XLEN  record address
- ready_o  out  1  record accepted when iretire_i && ready_o
- iretire_o  out  NrRetiredInstr  per-slot valid mask, packed from slot 0
- ilastsize_o  out  NrRetiredInstr×ILASTSIZE_LEN  per-slot size
- itype_o  out  NrRetiredInstr×ITYPE_LEN  per-slot type
- cause_o  out  CAUSE_LEN  group cause
- tval_o  out  XLEN  group tval
- priv_o  out  PRIV_LEN  group privilege
- iaddr_o  out  NrRetiredInstr×XLEN  per-slot address
- valid_o  out  1  bundle valid
- ready_i  in  1  bundle consumed when valid_o && ready_i

## Operation
- State: accumulation buffer (slots, count 0..N, group priv, cause/tval), pending flag (group closed but not yet transferred), output register (valid_o plus bundle fields), idle counter.
- Accepted record is written into slot[count], then count increments. The first record sets the group priv.
- Group closes when any of these holds:
  - count reaches N after a write;
  - the accepted record has itype≠0 (that record is the last slot);
  - the idle counter expires;
  - priv mismatch: iretire_i with count>0 and priv_i≠group priv. The existing group closes before the record is placed. The record starts a new group at slot 0 in the same cycle, only if the closed group transfers that cycle.
- Transfer: a closed group moves into the output register when valid_o=0 or (valid_o && ready_i). Otherwise pending=1.
- ready_o = !pending && !(priv mismatch && transfer not possible). It is combinational from state and iretire_i/priv_i.
- cause_o/tval_o are captured from the itype 1/2 record of the group, and are 0 otherwise.
- Unused slots: iretire_o bit 0, all per-slot fields 0.
- Idle counter: cleared on accept or when count=0. It increments each cycle with count>0 and no accept. It expires at TimeoutCycles−1.
- Bundles are delivered in order, with no loss and no duplication.

## Timing
- Reset (async assert, sync release): count=0, pending=0, idle=0, valid_o=0, all bundle outputs 0, ready_o=1.
- Latency: a group closed at edge t is on valid_o after edge t if transfer is possible, i.e. one cycle from accepting the closing record.
- Throughput: one record per cycle sustained when ready_i=1.
- Output register holds its value stable while valid_o && !ready_i.
- Pending group transfers on the edge where the output frees. ready_o returns to 1 the following cycle.
- Timeout: last accept at edge t0 with no further input gives valid_o high after edge t0+TimeoutCycles.
- Simultaneous closing record and output consumption: transfer happens the same edge, no bubble.
- Reset mid-operation discards all partial, pending and output groups immediately.

## Test plan
- Two itype 0 records at 0x80000000, 0x80000004, priv 3, ready_i=1 -> one cycle later valid_o=1, iretire_o=2'b11, iaddr_o[0]=0x80000000, iaddr_o[1]=0x80000004, priv_o=3.
- Single record itype=1, cause=2, tval=0xDEAD -> next cycle iretire_o=2'b01, itype_o[0]=1, cause_o=2, tval_o=0xDEAD, slot 1 all zero.
- Record A priv 3 then B priv 0 in consecutive cycles -> bundle {A} with priv_o=3, then after timeout bundle {B} with priv_o=0; ready_o stays 1.
- One record then idle with TimeoutCycles=16 -> valid_o rises exactly 16 edges after the accept, iretire_o=2'b01.
- ready_i=0, feed 5 sequential records -> bundle 1 held stable, group 2 pending, ready_o=0 on the 5th record. Raise ready_i -> bundles 1, 2, 3 delivered in order with correct addresses.
- Assert rst_i while valid_o=1 and count=1 -> all outputs 0 and ready_o=1 immediately. The next two records form a fresh bundle.
